// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM inter-stage pipeline registers.
// Occupancy state encoding, per-stage field widths and the NOP control word.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    localparam int DEF_CTRL_W   = 16;
    localparam int DEF_DATA_W   = 128;

    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 12;
    localparam int EXMEM_DATA_W = 96;
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 64;

    // All-zero control is a bubble: no write enables, no memory access.
    localparam logic [DEF_CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid bit plus ctrl and data fields, with load and clear.
// Clear always drops the slot to a NOP; data is zeroed only when CLEAR_DATA is set.
module pipe_entry #(
    parameter int                CTRL_W     = 16,
    parameter int                DATA_W     = 128,
    parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
    parameter bit                CLEAR_DATA = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: state uses <= so every slot samples pre-edge values, which is what
    // lets main load from skid in the same edge that skid is cleared.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_RST;
            if (CLEAR_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ctrl_d;
            data  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a one-entry skid buffer and flush.
// IN_READY depends only on the skid register, so there is no ready path through the stage.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                CTRL_W     = DEF_CTRL_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_RST   = CTRL_W'(NOP_CTRL),
    parameter bit                CLEAR_DATA = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY
);

    occ_state_t        state, state_nx;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;
    logic              accept, issue;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;

    assign IN_READY = !skid_valid && !RESET;
    assign accept   = IN_VALID && IN_READY;
    assign issue    = main_valid && OUT_READY;

    // NOTE: every control is given a default before the branches so the
    // decode stays purely combinational and no latch is inferred.
    always_comb begin
        state_nx       = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (FLUSH) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_nx   = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nx  = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nx  = FULL;
                    end else if (issue) begin
                        main_clear = 1'b1;
                        state_nx   = EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_nx       = BUSY;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : IN_CTRL;
    assign main_data_d = main_from_skid ? skid_data : IN_DATA;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CTRL_RST   (CTRL_RST),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (main_load),
        .clear  (main_clear),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CTRL_RST   (CTRL_RST),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (skid_load),
        .clear  (skid_clear),
        .ctrl_d (IN_CTRL),
        .data_d (IN_DATA),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
    );

    assign OUT_VALID = main_valid;
    assign OUT_CTRL  = main_ctrl;
    assign OUT_DATA  = main_data;
    assign OCCUPANCY = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: two instances (data cleared / data held on flush)
// share all inputs; accepted beats are queued and compared against the head every cycle.
module tb_pipe_stage_skid;

    localparam int              CW     = 16;
    localparam int              DW     = 32;
    localparam logic [CW-1:0]   NC_RST = 16'h00FF;

    logic          CLK, RESET, FLUSH, IN_VALID, OUT_READY;
    logic [CW-1:0] IN_CTRL;
    logic [DW-1:0] IN_DATA;
    logic          IN_READY, OUT_VALID;
    logic [CW-1:0] OUT_CTRL;
    logic [DW-1:0] OUT_DATA;
    logic [1:0]    OCCUPANCY;
    logic          nc_in_ready, nc_out_valid;
    logic [CW-1:0] nc_out_ctrl;
    logic [DW-1:0] nc_out_data;
    logic [1:0]    nc_occupancy;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cnt_20  = 0;
    logic             last_acc;
    logic [CW-1:0]    nxt;
    logic [CW+DW-1:0] sb[$];

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(16'h0000), .CLEAR_DATA(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL), .OUT_DATA(OUT_DATA),
        .OCCUPANCY(OCCUPANCY)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(NC_RST), .CLEAR_DATA(1'b0)) dut_nc (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(nc_in_ready), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
        .OUT_VALID(nc_out_valid), .OUT_READY(OUT_READY), .OUT_CTRL(nc_out_ctrl), .OUT_DATA(nc_out_data),
        .OCCUPANCY(nc_occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
        return {c ^ 16'hA5C3, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c);
        IN_VALID = v;
        IN_CTRL  = c;
        IN_DATA  = data_of(c);
    endtask

    // Called at the falling edge: outputs are settled, inputs for the next edge are applied.
    task automatic sample();
        logic             acc, iss;
        logic [CW+DW-1:0] head;
        acc = IN_VALID && IN_READY;
        iss = OUT_VALID && OUT_READY;
        check("in_ready",  IN_READY,     (sb.size() < 2) && !RESET);
        check("nc_ready",  nc_in_ready,  (sb.size() < 2) && !RESET);
        check("occupancy", OCCUPANCY,    sb.size());
        check("nc_occ",    nc_occupancy, sb.size());
        check("out_valid", OUT_VALID,    sb.size() != 0);
        check("nc_valid",  nc_out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            head = sb[0];
            check("head_ctrl",    OUT_CTRL,    head[CW+DW-1:DW]);
            check("head_data",    OUT_DATA,    head[DW-1:0]);
            check("nc_head_ctrl", nc_out_ctrl, head[CW+DW-1:DW]);
            check("nc_head_data", nc_out_data, head[DW-1:0]);
            if (iss) begin
                void'(sb.pop_front());
                if (head[CW+DW-1:DW] == 16'h0020) cnt_20++;
            end
        end else begin
            check("idle_ctrl",    OUT_CTRL,    16'h0000);
            check("idle_data",    OUT_DATA,    32'h0);
            check("nc_idle_ctrl", nc_out_ctrl, NC_RST);
        end
        if (FLUSH) sb.delete();
        else if (acc) sb.push_back({IN_CTRL, IN_DATA});
        last_acc = acc;
    endtask

    task automatic step();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
    endtask

    // Offer consecutive ctrl values starting at nxt until n are accepted, within a cycle budget.
    task automatic send(input int n);
        int got   = 0;
        int guard = 0;
        while (got < n && guard < 20) begin
            drive(1'b1, nxt);
            step();
            guard++;
            if (last_acc) begin
                got++;
                nxt++;
            end
        end
        drive(1'b0, nxt);
        check("send_done", got, n);
    endtask

    initial begin
        int acc_cnt;
        RESET = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        drive(1'b0, 16'h0);
        #1 RESET = 1'b1;

        // Reset values, including IN_READY held low by RESET.
        repeat (2) step();
        RESET = 1'b0;

        // Stream five beats at full rate.
        OUT_READY = 1'b1;
        nxt = 16'h0001;
        send(5);

        // Back-pressure: one extra beat lands in skid, then the stage closes.
        OUT_READY = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, nxt);
            step();
            if (last_acc) begin
                acc_cnt++;
                nxt++;
            end
        end
        check("bp_extra_beats", acc_cnt, 1);
        check("bp_occupancy", OCCUPANCY, 2);
        check("bp_in_ready", IN_READY, 0);

        // Release: order preserved.
        OUT_READY = 1'b1;
        send(3);
        repeat (4) step();

        // Flush in FULL: the offered beat 0x77 must never appear.
        OUT_READY = 1'b0;
        nxt = 16'h0010;
        send(2);
        check("full_before_flush", OCCUPANCY, 2);
        FLUSH = 1'b1;
        drive(1'b1, 16'h0077);
        step();
        FLUSH = 1'b0;
        drive(1'b0, 16'h0);
        check("flush_valid", OUT_VALID, 0);
        check("flush_ctrl", OUT_CTRL, 16'h0000);
        check("flush_data", OUT_DATA, 32'h0);
        check("flush_occ", OCCUPANCY, 0);
        check("nc_flush_valid", nc_out_valid, 0);
        check("nc_flush_ctrl", nc_out_ctrl, NC_RST);
        check("nc_flush_data_held", nc_out_data, data_of(16'h0010));
        OUT_READY = 1'b1;
        repeat (3) step();

        // Flush with simultaneous issue of head 0x20; 0xAA is discarded.
        OUT_READY = 1'b0;
        nxt = 16'h0020;
        send(1);
        FLUSH = 1'b1;
        OUT_READY = 1'b1;
        drive(1'b1, 16'h00AA);
        step();
        FLUSH = 1'b0;
        drive(1'b0, 16'h0);
        check("flush_issue_occ", OCCUPANCY, 0);
        check("flush_issue_valid", OUT_VALID, 0);
        repeat (3) step();
        check("head_issued_once", cnt_20, 1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            OUT_READY = ($urandom_range(0, 3) != 0);
            FLUSH     = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 16'($urandom_range(16'h0100, 16'h0FFF)));
            step();
        end
        FLUSH = 1'b0;
        drive(1'b0, 16'h0);
        OUT_READY = 1'b1;
        repeat (4) step();
        check("random_drained", sb.size(), 0);

        // Asynchronous reset between edges while FULL.
        OUT_READY = 1'b0;
        nxt = 16'h0030;
        send(2);
        check("full_before_reset", OCCUPANCY, 2);
        #2 RESET = 1'b1;
        #1;
        check("arst_valid", OUT_VALID, 0);
        check("arst_in_ready", IN_READY, 0);
        check("arst_occ", OCCUPANCY, 0);
        check("arst_ctrl", OUT_CTRL, 16'h0000);
        check("arst_data", OUT_DATA, 32'h0);
        check("nc_arst_valid", nc_out_valid, 0);
        check("nc_arst_ctrl", nc_out_ctrl, NC_RST);
        check("nc_arst_data", nc_out_data, 32'h0);
        sb.delete();
        @(posedge CLK);
        #1 RESET = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) step();

        // Post-reset traffic still works.
        nxt = 16'h0040;
        send(3);
        repeat (3) step();
        check("final_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
